// File: rtl/sr_ctrl_pkg.sv
// Shared types and sizing helper for the SR latch command conditioner.
// Used by the per-channel debouncer and by the arbitration top level.
package sr_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COUNT  = 2'd1,
      STABLE = 2'd2
   } deb_state_t;

   typedef enum logic [1:0] {
      NONE  = 2'd0,
      SET   = 2'd1,
      RESET = 2'd2
   } sr_cmd_t;

   // Bits needed to hold 0..max_val; never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sr_debounce_chan.sv
// One request channel: 2-flop synchroniser, debounce FSM, debounced level
// and a registered single-cycle pulse on each 0->1 transition of that level.
module sr_debounce_chan
   import sr_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_in,
   output logic rise
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYCLES);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_level_d;
   logic          r_rise;
   deb_state_t    r_state;
   logic [CW-1:0] r_cnt;

   deb_state_t    w_state_next;
   logic [CW-1:0] w_cnt_next;
   logic          w_level_next;

   // The level flips on the cycle the counter reaches DEBOUNCE_CYCLES, not one later.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_level_next = r_level;
      case (r_state)
         IDLE: begin
            if (r_sync2 != r_level) begin
               w_cnt_next = CW'(1);
               if (DEB_MAX == CW'(1)) begin
                  w_level_next = ~r_level;
                  w_state_next = STABLE;
               end else begin
                  w_state_next = COUNT;
               end
            end
         end
         COUNT: begin
            if (r_sync2 == r_level) begin
               w_cnt_next   = '0;
               w_state_next = IDLE;
            end else begin
               w_cnt_next = r_cnt + CW'(1);
               if (w_cnt_next == DEB_MAX) begin
                  w_level_next = ~r_level;
                  w_state_next = STABLE;
               end
            end
         end
         STABLE: begin
            w_cnt_next   = '0;
            w_state_next = IDLE;
         end
         default: begin
            w_cnt_next   = '0;
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_rise    <= 1'b0;
         r_state   <= IDLE;
         r_cnt     <= '0;
      end else begin
         r_sync1   <= raw_in;
         r_sync2   <= r_sync1;
         r_level   <= w_level_next;
         r_level_d <= r_level;
         r_rise    <= r_level & ~r_level_d;
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
      end
   end

   assign rise = r_rise;

endmodule

// File: rtl/sr_cmd_conditioner.sv
// Turns two bouncy asynchronous set/reset requests into single-cycle s/r/en
// commands for an enable-gated SR latch, rejecting conflicts and rate-limiting.
module sr_cmd_conditioner
   import sr_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int LOCKOUT_CYCLES  = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_set,
   input  logic raw_reset,
   output logic s,
   output logic r,
   output logic en,
   output logic conflict,
   output logic busy
);

   localparam int LW = cnt_width(LOCKOUT_CYCLES);
   localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES);

   logic          w_rise_set;
   logic          w_rise_rst;
   sr_cmd_t       w_cmd;
   logic          w_conflict;

   logic          r_s;
   logic          r_r;
   logic          r_en;
   logic          r_conflict;
   logic [LW-1:0] r_lock;

   sr_debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_set (
      .clk    (clk),
      .rst    (rst),
      .raw_in (raw_set),
      .rise   (w_rise_set)
   );

   sr_debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_rst (
      .clk    (clk),
      .rst    (rst),
      .raw_in (raw_reset),
      .rise   (w_rise_rst)
   );

   // Conflict wins over lockout so a simultaneous pair is always reported.
   always_comb begin
      w_cmd      = NONE;
      w_conflict = 1'b0;
      if (w_rise_set && w_rise_rst) begin
         w_conflict = 1'b1;
      end else if (r_lock != '0) begin
         w_cmd = NONE;
      end else if (w_rise_set) begin
         w_cmd = SET;
      end else if (w_rise_rst) begin
         w_cmd = RESET;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s        <= 1'b0;
         r_r        <= 1'b0;
         r_en       <= 1'b0;
         r_conflict <= 1'b0;
         r_lock     <= '0;
      end else begin
         r_s        <= (w_cmd == SET);
         r_r        <= (w_cmd == RESET);
         r_en       <= (w_cmd != NONE);
         r_conflict <= w_conflict;
         if (w_cmd != NONE) begin
            r_lock <= LOCK_LOAD;
         end else if (r_lock != '0) begin
            r_lock <= r_lock - LW'(1);
         end
      end
   end

   assign s        = r_s;
   assign r        = r_r;
   assign en       = r_en;
   assign conflict = r_conflict;
   assign busy     = (r_lock != '0);

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Directed bench for sr_cmd_conditioner with DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=4.
// Expected command cycle is first-high-sample edge + 7.
module tb_sr_cmd_conditioner;

   localparam int DEB  = 4;
   localparam int LOCK = 4;
   localparam int LAT  = DEB + 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic raw_set = 1'b0;
   logic raw_reset = 1'b0;
   logic s, r, en, conflict, busy;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   sr_cmd_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .LOCKOUT_CYCLES (LOCK)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .raw_set  (raw_set),
      .raw_reset(raw_reset),
      .s        (s),
      .r        (r),
      .en       (en),
      .conflict (conflict),
      .busy     (busy)
   );

   task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s cyc=%0d got=%b want=%b", tag, idx, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         tick();
         chk("rst_en", i, en, 1'b0);
         chk("rst_s", i, s, 1'b0);
         chk("rst_r", i, r, 1'b0);
         chk("rst_conflict", i, conflict, 1'b0);
         chk("rst_busy", i, busy, 1'b0);
      end
      rst = 1'b0;
   endtask

   // cmd: 0 none, 1 set, 2 reset. Index 0 is the first edge after this call.
   task automatic watch(input string name, input int n, input int en_at, input int cmd,
                        input int conf_at, input int raise_rst_at);
      logic exp_en, exp_busy;
      for (int i = 0; i < n; i++) begin
         if (i == raise_rst_at) raw_reset = 1'b1;
         tick();
         exp_en   = (i == en_at);
         exp_busy = (en_at >= 0) && (i >= en_at) && (i < en_at + LOCK);
         chk({name, "_en"}, i, en, exp_en);
         chk({name, "_s"}, i, s, exp_en && (cmd == 1));
         chk({name, "_r"}, i, r, exp_en && (cmd == 2));
         chk({name, "_conflict"}, i, conflict, (i == conf_at));
         chk({name, "_busy"}, i, busy, exp_busy);
         chk({name, "_sr_both"}, i, s & r, 1'b0);
      end
      $display("%s: %0d cycles checked, en expected at %0d", name, n, en_at);
   endtask

   initial begin
      // Clean set, then release (falling edge issues nothing).
      do_reset(3);
      raw_set = 1'b1;
      watch("clean_set", 14, LAT, 1, -1, -1);
      raw_set = 1'b0;
      watch("set_fall", 12, -1, 0, -1, -1);

      // Bounce rejection: 2 high / 2 low for 20 cycles, then held high.
      do_reset(2);
      for (int i = 0; i < 20; i++) begin
         raw_set = ((i / 2) % 2 == 0);
         tick();
         chk("bounce_en", i, en, 1'b0);
         chk("bounce_busy", i, busy, 1'b0);
      end
      $display("bounce: 20 toggle cycles checked");
      raw_set = 1'b1;
      watch("bounce_hold", 14, LAT, 1, -1, -1);
      raw_set = 1'b0;

      // Simultaneous requests: conflict once, never a command.
      do_reset(2);
      raw_set   = 1'b1;
      raw_reset = 1'b1;
      watch("simul", 16, -1, 0, LAT, -1);
      raw_set   = 1'b0;
      raw_reset = 1'b0;

      // Lockout drop: reset rise lands two cycles after the set command.
      do_reset(2);
      raw_set = 1'b1;
      watch("lock_drop", 16, LAT, 1, -1, 2);
      raw_reset = 1'b0;
      watch("lock_rst_fall", 12, -1, 0, -1, -1);
      raw_reset = 1'b1;
      watch("lock_fresh_rst", 14, LAT, 2, -1, -1);
      raw_set   = 1'b0;
      raw_reset = 1'b0;

      // Reset mid-count: rst lands 2 cycles before the debounced level would flip.
      do_reset(2);
      watch("idle_gap", 12, -1, 0, -1, -1);
      raw_reset = 1'b1;
      watch("mid_pre", DEB + 1 - 2, -1, 0, -1, -1);
      do_reset(3);
      watch("mid_post", 16, LAT, 2, -1, -1);
      raw_reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
